// File: rtl/pipe_ex_sched_if.sv
// ----------------------------------------------------------------------------
// pipe_ex_sched_if
//   Bundle of every signal exchanged between the pipe_ex issue scheduler and
//   its environment (two requesters plus the external pipe_ex datapath).
//
//   slave  : scheduler view
//   master : environment view (requesters drive operands, pipe_ex drives F)
//
//   en         1     issue enable (0 = stop accepting, in-flight ops drain)
//   req_valid  2     per-requester operand valid
//   req_ready  2     per-requester accept (one-hot or zero)
//   req_a..d   2*N   operands, requester i at [i*N +: N]
//   op_a..d    N     registered operands to pipe_ex
//   op_valid   1     op_* carry an issued op this cycle
//   pipe_f     N     F returned by pipe_ex
//   res_valid  1     single-cycle result strobe
//   res_id     1     owner of the result
//   res_data   N     registered result
//   outst0/1   4     in-flight count per requester
//   idle       1     nothing in flight and no result pending
// ----------------------------------------------------------------------------
interface pipe_ex_sched_if #(
  parameter int N = 100
);
  logic           en;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [2*N-1:0] req_c;
  logic [2*N-1:0] req_d;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [N-1:0]   op_c;
  logic [N-1:0]   op_d;
  logic           op_valid;
  logic [N-1:0]   pipe_f;
  logic           res_valid;
  logic           res_id;
  logic [N-1:0]   res_data;
  logic [3:0]     outst0;
  logic [3:0]     outst1;
  logic           idle;

  modport slave (
    input  en, req_valid, req_a, req_b, req_c, req_d, pipe_f,
    output req_ready, op_a, op_b, op_c, op_d, op_valid,
           res_valid, res_id, res_data, outst0, outst1, idle
  );

  modport master (
    output en, req_valid, req_a, req_b, req_c, req_d, pipe_f,
    input  req_ready, op_a, op_b, op_c, op_d, op_valid,
           res_valid, res_id, res_data, outst0, outst1, idle
  );
endinterface

// File: rtl/pipe_ex_sched.sv
// ----------------------------------------------------------------------------
// pipe_ex_sched
//   Round-robin issue scheduler that shares one external pipe_ex datapath
//   (F = ((A+B)+(C-D))*D, PIPE_LAT stages, no enable/reset) between two
//   requesters. Accepts at most one operand set per cycle, registers it onto
//   op_*, tracks the op with a {valid,id} tag shift register aligned to the
//   datapath latency, and returns F to its owner on res_*.
//
//   Handshake in cycle t -> op_valid in t+1 -> F on pipe_f in t+1+PIPE_LAT
//   -> res_valid in t+PIPE_LAT+2.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipe_ex_sched_if.slave (requests, datapath link, results, status)
// ----------------------------------------------------------------------------
module pipe_ex_sched #(
  parameter int N        = 100,
  parameter int PIPE_LAT = 3,
  parameter int MAX_OUT  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_ex_sched_if.slave bus
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  // Arbitration
  logic [1:0] elig;
  logic [1:0] grant;
  logic       handshake;
  logic       win_id;
  logic       rr_q, rr_d;

  // Issue registers
  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;
  logic [N-1:0] op_c_q, op_c_d;
  logic [N-1:0] op_d_q, op_d_d;

  // Tag pipe: stage 0 coincides with op_valid, stage PIPE_LAT with pipe_f
  logic [PIPE_LAT:0] tag_v_q, tag_v_d;
  logic [PIPE_LAT:0] tag_id_q, tag_id_d;

  // Result registers
  logic         res_valid_q, res_valid_d;
  logic         res_id_q, res_id_d;
  logic [N-1:0] res_data_q, res_data_d;

  // Per-requester in-flight counters
  logic [3:0] outst_q [2];
  logic [3:0] outst_d [2];
  logic [1:0] cnt_inc;
  logic [1:0] cnt_dec;

  // --------------------------------------------------------------------------
  // Eligibility and round-robin grant
  // --------------------------------------------------------------------------
  always_comb begin : arb_comb
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    elig = '0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = bus.en & bus.req_valid[i] & (outst_q[i] < MAX_OUT_C);
    end

    grant = elig;
    if (elig == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end

    handshake = |grant;
    win_id    = grant[1];
    // Priority passes to the requester that lost (or did not ask) this time.
    rr_d      = handshake ? ~win_id : rr_q;
  end

  // --------------------------------------------------------------------------
  // Issue, tag pipe, result capture, counters
  // --------------------------------------------------------------------------
  always_comb begin : data_comb
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    op_c_d = op_c_q;
    op_d_d = op_d_q;
    if (handshake) begin
      op_a_d = win_id ? bus.req_a[N +: N] : bus.req_a[0 +: N];
      op_b_d = win_id ? bus.req_b[N +: N] : bus.req_b[0 +: N];
      op_c_d = win_id ? bus.req_c[N +: N] : bus.req_c[0 +: N];
      op_d_d = win_id ? bus.req_d[N +: N] : bus.req_d[0 +: N];
    end

    tag_v_d  = {tag_v_q[PIPE_LAT-1:0], handshake};
    tag_id_d = {tag_id_q[PIPE_LAT-1:0], win_id};

    // The tail tag describes whatever pipe_f carries this cycle; an empty
    // tail means pipe_f is stale and must not be delivered.
    res_valid_d = tag_v_q[PIPE_LAT];
    res_id_d    = tag_v_q[PIPE_LAT] ? tag_id_q[PIPE_LAT] : res_id_q;
    res_data_d  = tag_v_q[PIPE_LAT] ? bus.pipe_f : res_data_q;

    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = grant[i];
      cnt_dec[i] = res_valid_q & (res_id_q == i[0]);
      outst_d[i] = outst_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        outst_d[i] = outst_q[i] + 4'd1;
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        outst_d[i] = outst_q[i] - 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      op_d_q      <= '0;
      // NOTE: the tag pipe must be cleared on reset even though pipe_ex itself
      // cannot be; the tags are what make stale pipe_f contents harmless.
      tag_v_q     <= '0;
      tag_id_q    <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      outst_q[0]  <= '0;
      outst_q[1]  <= '0;
    end else begin
      rr_q        <= rr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      op_d_q      <= op_d_d;
      tag_v_q     <= tag_v_d;
      tag_id_q    <= tag_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      outst_q[0]  <= outst_d[0];
      outst_q[1]  <= outst_d[1];
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_ready = grant;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_c      = op_c_q;
  assign bus.op_d      = op_d_q;
  assign bus.op_valid  = tag_v_q[0];
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.outst0    = outst_q[0];
  assign bus.outst1    = outst_q[1];
  assign bus.idle      = (outst_q[0] == 4'd0) && (outst_q[1] == 4'd0) && !res_valid_q;

endmodule

// File: tb/tb_pipe_ex_sched.sv
// ----------------------------------------------------------------------------
// tb_pipe_ex_sched
//   Drives two requesters into pipe_ex_sched, models the external 3-stage
//   pipe_ex datapath, and checks the scheduler against an independent
//   arbitration/counter model plus a scoreboard of expected results.
// ----------------------------------------------------------------------------
module tb_pipe_ex_sched;

  localparam int N        = 100;
  localparam int PIPE_LAT = 3;
  localparam int MAX_OUT  = 4;
  localparam int RES_LAT  = PIPE_LAT + 2;

  typedef struct {
    logic         id;
    logic [N-1:0] data;
    int           due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  pipe_ex_sched_if #(.N(N)) bus ();

  pipe_ex_sched #(.N(N), .PIPE_LAT(PIPE_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock, period 20
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External pipe_ex: three register stages, no enable, no reset
  logic [N-1:0] s1_sum, s1_dif, s1_d, s2_sum, s2_d, s3_f;
  always @(posedge clk) begin
    s1_sum <= bus.op_a + bus.op_b;
    s1_dif <= bus.op_c - bus.op_d;
    s1_d   <= bus.op_d;
    s2_sum <= s1_sum + s1_dif;
    s2_d   <= s1_d;
    s3_f   <= s2_sum * s2_d;
  end
  assign bus.pipe_f = s3_f;

  function automatic logic [N-1:0] f_model(input logic [N-1:0] a, b, c, d);
    logic [N-1:0] s;
    s = (a + b) + (c - d);
    return s * d;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model + scoreboard, evaluated every falling edge
  // --------------------------------------------------------------------------
  exp_t       sb[$];
  exp_t       m_exp;
  int         mdl_out[2];
  logic       mdl_rr;
  logic [1:0] m_elig;
  logic [1:0] m_grant;
  int         m_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mdl_out[0] = 0;
      mdl_out[1] = 0;
      mdl_rr     = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_elig[i] = bus.en & bus.req_valid[i] & (mdl_out[i] < MAX_OUT);
      end
      m_grant = m_elig;
      if (m_elig == 2'b11) m_grant = mdl_rr ? 2'b10 : 2'b01;

      checks++;
      if (bus.req_ready !== m_grant) begin
        errors++;
        $display("FAIL ready cyc=%0d: got %b expected %b", cyc, bus.req_ready, m_grant);
      end
      checks++;
      if (bus.outst0 !== 4'(mdl_out[0])) begin
        errors++;
        $display("FAIL outst0 cyc=%0d: got %0d expected %0d", cyc, bus.outst0, mdl_out[0]);
      end
      checks++;
      if (bus.outst1 !== 4'(mdl_out[1])) begin
        errors++;
        $display("FAIL outst1 cyc=%0d: got %0d expected %0d", cyc, bus.outst1, mdl_out[1]);
      end
      checks++;
      if (bus.idle !== ((mdl_out[0] == 0) && (mdl_out[1] == 0))) begin
        errors++;
        $display("FAIL idle cyc=%0d: got %b expected %b", cyc, bus.idle,
                 (mdl_out[0] == 0) && (mdl_out[1] == 0));
      end

      checks++;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        m_exp = sb.pop_front();
        if (bus.res_valid !== 1'b1 || bus.res_id !== m_exp.id || bus.res_data !== m_exp.data) begin
          errors++;
          $display("FAIL result cyc=%0d: got v=%b id=%b data=%0d expected v=1 id=%b data=%0d",
                   cyc, bus.res_valid, bus.res_id, bus.res_data, m_exp.id, m_exp.data);
        end
        mdl_out[m_exp.id] = mdl_out[m_exp.id] - 1;
      end else if (bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_result cyc=%0d: got res_valid=%b expected 0", cyc, bus.res_valid);
      end

      if (m_grant != 2'b00) begin
        m_w = m_grant[1] ? 1 : 0;
        sb.push_back('{id:   m_grant[1],
                       data: f_model(bus.req_a[m_w*N +: N], bus.req_b[m_w*N +: N],
                                     bus.req_c[m_w*N +: N], bus.req_d[m_w*N +: N]),
                       due:  cyc + RES_LAT});
        mdl_out[m_w] = mdl_out[m_w] + 1;
        mdl_rr       = ~m_grant[1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, b, c, d);
    bus.req_a[i*N +: N] = a;
    bus.req_b[i*N +: N] = b;
    bus.req_c[i*N +: N] = c;
    bus.req_d[i*N +: N] = d;
  endtask

  task automatic apply_reset();
    step();
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    bus.en        = 1'b1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_res(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_res timeout: got no res_valid within %0d cycles, required one", max_cyc);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (bus.idle === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_idle timeout: idle=%b after %0d cycles, required 1", bus.idle, max_cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b00 || bus.op_valid !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b op_valid=%b res_valid=%b res_id=%b required all 0",
               bus.req_ready, bus.op_valid, bus.res_valid, bus.res_id);
    end
    checks++;
    if (bus.op_a !== '0 || bus.op_b !== '0 || bus.op_c !== '0 || bus.op_d !== '0 ||
        bus.res_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got op_a=%0d op_b=%0d op_c=%0d op_d=%0d res_data=%0d required 0",
               bus.op_a, bus.op_b, bus.op_c, bus.op_d, bus.res_data);
    end
    checks++;
    if (bus.outst0 !== 4'd0 || bus.outst1 !== 4'd0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_status: got outst0=%0d outst1=%0d idle=%b required 0 0 1",
               bus.outst0, bus.outst1, bus.idle);
    end
  endtask

  task automatic test_single();
    int hs;
    bit ok;
    apply_reset();
    set_req(0, 10, 12, 6, 3);
    bus.req_valid = 2'b01;
    @(negedge clk);
    hs = cyc;
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_accept: got ready=%b required 01", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.op_valid !== 1'b1 || bus.op_a !== 100'd10 || bus.op_d !== 100'd3) begin
      errors++;
      $display("FAIL single_issue: got op_valid=%b op_a=%0d op_d=%0d required 1 10 3",
               bus.op_valid, bus.op_a, bus.op_d);
    end
    wait_res(10, ok);
    if (ok) begin
      checks++;
      if (cyc != hs + 5) begin
        errors++;
        $display("FAIL single_latency: got %0d cycles required 5", cyc - hs);
      end
      checks++;
      if (bus.res_id !== 1'b0 || bus.res_data !== 100'd75) begin
        errors++;
        $display("FAIL single_result: got id=%b data=%0d required id=0 data=75",
                 bus.res_id, bus.res_data);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL single_idle: got idle=%b required 1", bus.idle);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0] exp_g;
    apply_reset();
    set_req(0, 10, 10, 5, 3);
    set_req(1, 20, 11, 1, 4);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (bus.req_ready !== exp_g) begin
        errors++;
        $display("FAIL contention_grant%0d: got %b required %b", k, bus.req_ready, exp_g);
      end
      step();
    end
    bus.req_valid = 2'b00;
    wait_res(10, ok);
    if (ok) begin
      checks++;
      if (bus.res_id !== 1'b0 || bus.res_data !== 100'd66) begin
        errors++;
        $display("FAIL contention_res0: got id=%b data=%0d required id=0 data=66",
                 bus.res_id, bus.res_data);
      end
      step();
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 || bus.res_data !== 100'd112) begin
        errors++;
        $display("FAIL contention_res1: got v=%b id=%b data=%0d required v=1 id=1 data=112",
                 bus.res_valid, bus.res_id, bus.res_data);
      end
    end
    wait_idle(20);
  endtask

  task automatic test_limit();
    logic exp_r;
    apply_reset();
    set_req(0, 1, 2, 3, 4);
    bus.req_valid = 2'b01;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_r = (k < 4);
      checks++;
      if (bus.req_ready[0] !== exp_r) begin
        errors++;
        $display("FAIL limit_ready%0d: got %b required %b", k, bus.req_ready[0], exp_r);
      end
      if (k >= 4) begin
        checks++;
        if (bus.outst0 !== 4'd4) begin
          errors++;
          $display("FAIL limit_full%0d: got outst0=%0d required 4", k, bus.outst0);
        end
      end
      step();
    end
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      checks++;
      if (bus.outst0 > 4'd4) begin
        errors++;
        $display("FAIL limit_cap: got outst0=%0d required <= 4", bus.outst0);
      end
      step();
    end
    bus.req_valid = 2'b00;
    wait_idle(20);
  endtask

  task automatic test_drain();
    int nres;
    apply_reset();
    set_req(0, 5, 6, 7, 1);
    set_req(1, 9, 9, 9, 9);
    bus.req_valid = 2'b01;
    repeat (3) step();
    bus.en        = 1'b0;
    bus.req_valid = 2'b11;
    nres = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL drain_ready%0d: got %b required 00", k, bus.req_ready);
      end
      if (bus.res_valid === 1'b1) nres++;
      step();
    end
    @(negedge clk);
    checks++;
    if (nres != 3) begin
      errors++;
      $display("FAIL drain_count: got %0d results required 3", nres);
    end
    checks++;
    if (bus.outst0 !== 4'd0 || bus.outst1 !== 4'd0 || bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL drain_final: got outst0=%0d outst1=%0d idle=%b required 0 0 1",
               bus.outst0, bus.outst1, bus.idle);
    end
    step();
    bus.en        = 1'b1;
    bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    int hs;
    bit ok;
    apply_reset();
    set_req(0, 1, 1, 1, 1);
    bus.req_valid = 2'b01;
    repeat (3) step();
    bus.req_valid = 2'b00;
    rst_n         = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.res_valid !== 1'b0 || bus.outst0 !== 4'd0 || bus.outst1 !== 4'd0) begin
        errors++;
        $display("FAIL midreset_quiet%0d: got res_valid=%b outst0=%0d outst1=%0d required 0 0 0",
                 k, bus.res_valid, bus.outst0, bus.outst1);
      end
      step();
    end
    set_req(1, 7, 8, 9, 2);
    bus.req_valid = 2'b10;
    @(negedge clk);
    hs = cyc;
    step();
    bus.req_valid = 2'b00;
    wait_res(10, ok);
    if (ok) begin
      checks++;
      if (cyc != hs + 5 || bus.res_id !== 1'b1 || bus.res_data !== 100'd44) begin
        errors++;
        $display("FAIL midreset_next: got lat=%0d id=%b data=%0d required lat=5 id=1 data=44",
                 cyc - hs, bus.res_id, bus.res_data);
      end
    end
    wait_idle(10);
  endtask

  task automatic test_same_cycle();
    apply_reset();
    set_req(0, 2, 3, 4, 5);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    repeat (4) step();
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.req_ready !== 2'b01 || bus.outst0 !== 4'd1 ||
        bus.res_data !== 100'd20) begin
      errors++;
      $display("FAIL same_cycle_pre: got res_valid=%b ready=%b outst0=%0d data=%0d required 1 01 1 20",
               bus.res_valid, bus.req_ready, bus.outst0, bus.res_data);
    end
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.outst0 !== 4'd1) begin
      errors++;
      $display("FAIL same_cycle_post: got outst0=%0d required 1", bus.outst0);
    end
    wait_idle(10);
  endtask

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.req_d     = '0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    test_reset();
    test_single();
    test_contention();
    test_limit();
    test_drain();
    test_reset_mid();
    test_same_cycle();

    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending results required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
